// File: rtl/wide_load_sequencer_pkg.sv
// Shared types and constants for the wide-load sequencer: requester indices,
// FSM state encoding and an index-width helper.
package wide_load_sequencer_pkg;

  localparam int NUM_REQ = 3;

  localparam int REQ_IR  = 0;
  localparam int REQ_MAR = 1;
  localparam int REQ_JR  = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    LD_HI,
    RD_LO,
    LD_LO,
    DONE
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_load_sequencer_rr_arbiter.sv
// Round-robin selector: scans requests starting at the pointer and returns the
// first hit as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[IDX_W'(j)]) begin
        found                 = 1'b1;
        grant_o[IDX_W'(j)]    = 1'b1;
        idx_o                 = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/wide_load_sequencer.sv
// Serves 16-bit register loads from a byte-wide memory: two byte reads per
// grant, each followed by a one-cycle high/low load strobe, then a done pulse.
module wide_load_sequencer #(
  parameter int NUM_REQ = wide_load_sequencer_pkg::NUM_REQ,
  parameter int ADDR_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ready,
  input  logic [7:0]                mem_rdata,
  output logic [7:0]                halfvalue_out,
  output logic [NUM_REQ-1:0]        loadhigh,
  output logic [NUM_REQ-1:0]        loadlow,
  output logic [NUM_REQ-1:0]        done
);

  import wide_load_sequencer_pkg::*;

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          data_q, data_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [ADDR_W-1:0]   grant_addr;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so all registers update from the same
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  // Index and base are latched only at grant, so later req/req_addr changes
  // cannot disturb a transaction in flight.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (grant != '0) begin
          idx_d   = grant_idx;
          base_d  = grant_addr;
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = LD_HI;
        end
      end
      LD_HI: state_d = RD_LO;
      RD_LO: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          state_d = LD_LO;
        end
      end
      LD_LO: state_d = DONE;
      DONE: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_addr      = '0;
    halfvalue_out = '0;
    loadhigh      = '0;
    loadlow       = '0;
    done          = '0;
    unique case (state_q)
      RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = base_q;
      end
      LD_HI: begin
        loadhigh[idx_q] = 1'b1;
        halfvalue_out   = data_q;
      end
      RD_LO: begin
        mem_req  = 1'b1;
        mem_addr = base_q + ADDR_W'(1);
      end
      LD_LO: begin
        loadlow[idx_q] = 1'b1;
        halfvalue_out  = data_q;
      end
      DONE:    done[idx_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wide_load_sequencer.sv
// Scoreboard bench for wide_load_sequencer: stimulus predicts each transaction
// from a round-robin model and a memory image; a monitor checks DUT activity.
module tb_wide_load_sequencer;

  localparam int N  = 3;
  localparam int AW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic [7:0]      mem_rdata;
  logic [7:0]      halfvalue_out;
  logic [N-1:0]    loadhigh;
  logic [N-1:0]    loadlow;
  logic [N-1:0]    done;

  always #5 clock = ~clock;

  wide_load_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_addr      (req_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .halfvalue_out (halfvalue_out),
    .loadhigh      (loadhigh),
    .loadlow       (loadlow),
    .done          (done)
  );

  typedef struct {
    int          idx;
    logic [15:0] base;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          lat;
    bit          abort;
  } txn_t;

  typedef struct {
    int hw;
    int lw;
  } plan_t;

  txn_t        exp_q[$];
  plan_t       plan_q[$];
  logic [7:0]  mem [65536];
  logic [15:0] addr_tb [N];
  int          n_vec = 0;
  int          n_err = 0;
  int          ptr_m = 0;
  bit          mon_active = 1'b0;
  logic [N-1:0] raise_mask = '0;
  logic [N-1:0] drop_mask  = '0;
  int          hold_cmd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_addrs();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tb[i];
  endtask

  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Expected response for one transaction; the matching memory wait plan is
  // queued in the same grant order.
  task automatic expect_txn(input int idx, input int hw, input int lw, input bit abort);
    txn_t        t;
    plan_t       p;
    logic [15:0] lo_a;
    t.idx   = idx;
    t.base  = addr_tb[idx];
    lo_a    = t.base + 16'd1;
    t.hi    = mem[t.base];
    t.lo    = mem[lo_a];
    t.lat   = 4 + hw + lw;
    t.abort = abort;
    exp_q.push_back(t);
    p.hw = hw;
    p.lw = lw;
    plan_q.push_back(p);
    if (!abort) ptr_m = (idx + 1) % N;
  endtask

  task automatic raise(input logic [N-1:0] m, input int hold);
    raise_mask = m;
    hold_cmd   = hold;
    tick();
    raise_mask = '0;
    hold_cmd   = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size() != 0 || mon_active), 32'd0);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // Requesters: hold their bit until their done pulse (or a forced drop).
  initial begin : requester
    int hold_left;
    hold_left = 0;
    req       = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        req       = '0;
        hold_left = 0;
      end else begin
        if (done != '0) begin
          if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) req = '0;
          end else begin
            req = req & ~done;
          end
        end
        req = req & ~drop_mask;
        if (raise_mask != '0) begin
          req       = req | raise_mask;
          hold_left = hold_cmd;
        end
      end
    end
  end

  // Memory: answers each read after the planned number of wait cycles.
  initial begin : responder
    bit    in_read;
    int    rd_num, cnt, tgt;
    plan_t p;
    in_read   = 1'b0;
    rd_num    = 0;
    cnt       = 0;
    tgt       = 0;
    p.hw      = 0;
    p.lw      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_read   = 1'b0;
        rd_num    = 0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!in_read) begin
          in_read = 1'b1;
          cnt     = 0;
          if (rd_num % 2 == 0) begin
            if (plan_q.size() > 0) p = plan_q.pop_front();
            else begin
              p.hw = 0;
              p.lw = 0;
            end
            tgt = p.hw;
          end else begin
            tgt = p.lw;
          end
        end
        if (cnt >= tgt) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          in_read   = 1'b0;
          rd_num++;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 8'($urandom);
          cnt++;
        end
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
    end
  end

  initial begin : monitor
    txn_t         cur;
    int           age;
    bit           hi_ld, lo_ld;
    logic [15:0]  exp_addr;
    logic [N-1:0] oh;
    age   = 0;
    hi_ld = 1'b0;
    lo_ld = 1'b0;
    cur   = '{idx: 0, base: '0, hi: '0, lo: '0, lat: 0, abort: 1'b0};
    forever begin
      @(negedge clock);
      if (mon_active) age++;
      if (mem_req === 1'b1 && !mon_active) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_read: mem_addr %0h with no transaction pending", mem_addr);
        end else begin
          cur        = exp_q.pop_front();
          mon_active = 1'b1;
          age        = 0;
          hi_ld      = 1'b0;
          lo_ld      = 1'b0;
        end
      end
      if (mem_req === 1'b1 && mon_active) begin
        exp_addr = hi_ld ? cur.base + 16'd1 : cur.base;
        if (hi_ld) check("lo_addr", 32'(mem_addr), 32'(exp_addr));
        else       check("hi_addr", 32'(mem_addr), 32'(exp_addr));
      end
      if ((loadhigh | loadlow | done) != '0) begin
        check("mem_req_idle_in_load", 32'(mem_req), 32'd0);
        if (!mon_active) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_strobe: loadhigh %0b loadlow %0b done %0b outside a transaction",
                   loadhigh, loadlow, done);
        end else begin
          oh = '0;
          oh[cur.idx] = 1'b1;
          if (loadhigh != '0) begin
            check("loadhigh_strobe", 32'({loadhigh, loadlow, done}), 32'({oh, 3'b000, 3'b000}));
            check("hi_byte", 32'(halfvalue_out), 32'(cur.hi));
            check("hi_order", 32'({hi_ld, lo_ld}), 32'd0);
            hi_ld = 1'b1;
          end else if (loadlow != '0) begin
            check("loadlow_strobe", 32'({loadhigh, loadlow, done}), 32'({3'b000, oh, 3'b000}));
            check("lo_byte", 32'(halfvalue_out), 32'(cur.lo));
            check("lo_order", 32'({hi_ld, lo_ld}), 32'b10);
            lo_ld = 1'b1;
          end else begin
            check("done_strobe", 32'({loadhigh, loadlow, done}), 32'({3'b000, 3'b000, oh}));
            check("done_after_lo", 32'(lo_ld), 32'd1);
            check("latency", 32'(age), 32'(cur.lat));
            check("not_aborted", 32'(cur.abort), 32'd0);
            mon_active = 1'b0;
          end
        end
      end
      if (reset === 1'b1 && mon_active) begin
        check("abort_expected", 32'(cur.abort), 32'd1);
        check("abort_no_loadlow", 32'(lo_ld), 32'd0);
        mon_active = 1'b0;
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] r, rr;
    logic [15:0]  lo_a;
    int           w, n;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < N; i++) addr_tb[i] = 16'($urandom);
    drive_addrs();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_mem_if", 32'({mem_req, mem_addr}), 32'd0);
    check("rst_strobes", 32'({halfvalue_out, loadhigh, loadlow, done}), 32'd0);
    reset = 1'b0;
    ptr_m = 0;
    tick();

    // All three requesting continuously: four grants rotate 0,1,2,0.
    for (int k = 0; k < 4; k++) begin
      w = winner(3'b111, ptr_m);
      expect_txn(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
    raise(3'b111, 4);
    wait_idle("hold_all_timeout");

    // Instruction load from 0x1234, zero-wait memory.
    addr_tb[0]       = 16'h1234;
    mem[16'h1234]    = 8'hAB;
    mem[16'h1235]    = 8'hCD;
    drive_addrs();
    expect_txn(0, 0, 0, 1'b0);
    raise(3'b001, 0);
    check("grant_mem_req", 32'(mem_req), 32'd1);
    check("grant_mem_addr", 32'(mem_addr), 32'h1234);
    wait_idle("ir_1234_timeout");

    // Address wrap on the low-byte read.
    addr_tb[0] = 16'hFFFF;
    drive_addrs();
    expect_txn(0, 0, 0, 1'b0);
    raise(3'b001, 0);
    wait_idle("wrap_timeout");

    // Four wait cycles on the low read.
    addr_tb[0] = 16'($urandom);
    drive_addrs();
    expect_txn(0, 0, 4, 1'b0);
    raise(3'b001, 0);
    wait_idle("lo_wait_timeout");

    // Requester 1 drops req and scribbles its address after the high load.
    addr_tb[1] = 16'($urandom);
    drive_addrs();
    expect_txn(1, 0, 1, 1'b0);
    raise(3'b010, 0);
    n = 0;
    while (!loadhigh[1] && n < 20) begin
      tick();
      n++;
    end
    check("ld_hi_seen", 32'(loadhigh[1]), 32'd1);
    drop_mask  = 3'b010;
    addr_tb[1] = ~addr_tb[1];
    drive_addrs();
    tick();
    drop_mask = '0;
    check("req1_dropped", 32'(req[1]), 32'd0);
    wait_idle("drop_timeout");

    // Reset while stalled in the low read of requester 2.
    addr_tb[2] = 16'($urandom);
    drive_addrs();
    expect_txn(2, 0, 6, 1'b1);
    raise(3'b100, 0);
    lo_a = addr_tb[2] + 16'd1;
    n = 0;
    while (!(mem_req && mem_addr == lo_a) && n < 30) begin
      tick();
      n++;
    end
    check("rd_lo_reached", 32'(mem_req && mem_addr == lo_a), 32'd1);
    pulse_reset();
    check("abort_mem_if", 32'({mem_req, mem_addr}), 32'd0);
    check("abort_strobes", 32'({halfvalue_out, loadhigh, loadlow, done}), 32'd0);
    repeat (4) tick();
    addr_tb[1] = 16'($urandom);
    drive_addrs();
    expect_txn(winner(3'b010, ptr_m), 0, 0, 1'b0);
    raise(3'b010, 0);
    wait_idle("post_reset_timeout");

    // Leave the pointer at 1, reset, then 0 must win over 1.
    addr_tb[0] = 16'($urandom);
    drive_addrs();
    expect_txn(0, 0, 0, 1'b0);
    raise(3'b001, 0);
    wait_idle("ptr_setup_timeout");
    pulse_reset();
    tick();
    rr = 3'b011;
    while (rr != '0) begin
      w = winner(rr, ptr_m);
      expect_txn(w, 0, 0, 1'b0);
      rr[w] = 1'b0;
    end
    raise(3'b011, 0);
    wait_idle("ptr_reset_timeout");

    // Randomized batches of simultaneous requests with random memory waits.
    for (int b = 0; b < 30; b++) begin
      r = N'($urandom_range(1, 7));
      for (int i = 0; i < N; i++)
        addr_tb[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive_addrs();
      rr = r;
      while (rr != '0) begin
        w = winner(rr, ptr_m);
        expect_txn(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        rr[w] = 1'b0;
      end
      raise(r, 0);
      wait_idle("random_timeout");
    end

    repeat (5) tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("plan_q_drained", 32'(plan_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wide_load_sequencer.md
WIDE_LOAD_SEQUENCER -- requirements
Module: wide_load_sequencer

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of 16-bit register requesters (0=instruction, 1=memory address, 2=jump).
REQ-002 Parameter ADDR_W, default 16, SHALL set the memory address width.
REQ-003 Port clock, input, 1, SHALL be the single clock; all state updates on posedge clock.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port req, input, NUM_REQ, SHALL carry one request bit per requester, held high until that requester's done pulse.
REQ-006 Port req_addr, input, NUM_REQ*ADDR_W, SHALL carry each requester's byte address, packed with requester i at bits [i*ADDR_W +: ADDR_W].
REQ-007 Port mem_req, output, 1, SHALL be the byte-read request to memory.
REQ-008 Port mem_addr, output, ADDR_W, SHALL be the byte-read address.
REQ-009 Port mem_ready, input, 1, SHALL complete a read in any cycle where mem_req and mem_ready are both high.
REQ-010 Port mem_rdata, input, 8, SHALL carry the read byte, valid when mem_ready is high.
REQ-011 Port halfvalue_out, output, 8, SHALL be the byte driven to all 16-bit registers' halfvaluein.
REQ-012 Port loadhigh, output, NUM_REQ, SHALL be a one-hot high-byte load strobe per register.
REQ-013 Port loadlow, output, NUM_REQ, SHALL be a one-hot low-byte load strobe per register.
REQ-014 Port done, output, NUM_REQ, SHALL pulse for one cycle to the served requester.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_HI, LD_HI, RD_LO, LD_LO and DONE.
REQ-016 In IDLE with any req bit high, the round-robin arbiter SHALL pick one index, latch it together with its req_addr, and move to RD_HI.
REQ-017 Round-robin: priority SHALL start at the pointer; after DONE the pointer SHALL become the served index+1, wrapping from NUM_REQ-1 to 0.
REQ-018 In RD_HI, mem_req SHALL be 1 and mem_addr SHALL equal the latched base; on mem_ready, mem_rdata SHALL be captured and the FSM SHALL move to LD_HI.
REQ-019 In LD_HI, loadhigh[idx] SHALL be 1 for exactly one cycle, halfvalue_out SHALL equal the captured byte, and the next state SHALL be RD_LO.
REQ-020 In RD_LO, mem_req SHALL be 1 and mem_addr SHALL equal base+1 modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000); on mem_ready the FSM SHALL move to LD_LO.
REQ-021 In LD_LO, loadlow[idx] SHALL be 1 for exactly one cycle with halfvalue_out equal to the captured low byte, and the next state SHALL be DONE.
REQ-022 In DONE, done[idx] SHALL be 1 for one cycle and the next state SHALL be IDLE; a new grant is therefore possible no earlier than the cycle after DONE.
REQ-023 While mem_req is high and mem_ready is low, mem_addr SHALL hold stable and mem_req SHALL stay high, with no timeout.
REQ-024 Outside RD_HI/RD_LO, mem_req SHALL be 0.
REQ-025 At most one bit across loadhigh|loadlow SHALL be high in any cycle.
REQ-026 A req dropped mid-transaction SHALL be ignored: the transaction SHALL complete.
REQ-027 A req_addr change after the grant SHALL have no effect.
REQ-028 With zero-wait memory, the latency from a req sampled in IDLE at cycle T to the done pulse SHALL be cycle T+5.

Reset
REQ-029 On reset, the FSM SHALL return to IDLE from any state, including mid-read, with no further strobes issued.
REQ-030 On reset, mem_req, mem_addr, halfvalue_out, loadhigh, loadlow and done SHALL be 0, and the round-robin pointer SHALL be 0.

Structure
REQ-031 A shared package SHALL hold the state enum, NUM_REQ and the requester index constants REQ_IR=0, REQ_MAR=1, REQ_JR=2.
REQ-032 A sub-module rr_arbiter SHALL perform the round-robin selection (inputs: req and pointer; output: one-hot grant plus index).

Verification
REQ-033 Bench SHALL cover: req=3'b001, base 16'h1234, memory returns 8'hAB then 8'hCD with zero wait -> loadhigh[0] with AB, then loadlow[0] with CD, done[0] at T+5, mem_addr 1234 then 1235.
REQ-034 Bench SHALL cover: base 16'hFFFF -> second read at mem_addr 16'h0000.
REQ-035 Bench SHALL cover: req=3'b111 held continuously -> grant order 0,1,2,0, with exactly one done per transaction.
REQ-036 Bench SHALL cover: mem_ready held low 4 cycles in RD_LO -> mem_addr stable, no loadlow until ready, latency T+9.
REQ-037 Bench SHALL cover: reset asserted in RD_LO -> next cycle IDLE, all outputs 0, no loadlow/done for that transaction; after release, req=3'b010 is granted first (pointer 0 scan).
REQ-038 Bench SHALL cover: req[1] dropped in LD_HI -> transaction still completes with done[1].
